// File: rtl/mem_bus_controller_pkg.sv
// Shared encodings for the memory bus controller: FSM states, write data
// register output-select codes and the byte-enable helper.
package mem_bus_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // write_data_register data_out_sel codes
    localparam logic [1:0] WDR_SEL_HIZ   = 2'b00;
    localparam logic [1:0] WDR_SEL_PASS  = 2'b01;
    localparam logic [1:0] WDR_SEL_LATCH = 2'b10;

    function automatic logic [3:0] byte_enables(input logic is_byte, input logic [1:0] lane);
        return is_byte ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_bus_controller_if.sv
// CPU request/response and external memory bus signals of the controller.
// master = the controller, slave = CPU plus memory side.
interface mem_bus_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [1:0]  wdr_sel;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        input  req_valid, req_write, req_byte, req_addr, mem_ready, mem_rdata,
        output req_ready, wdr_sel, mem_addr, mem_be, mem_we, mem_req,
               rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        output req_valid, req_write, req_byte, req_addr, mem_ready, mem_rdata,
        input  req_ready, wdr_sel, mem_addr, mem_be, mem_we, mem_req,
               rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_bus_controller_read_data_align.sv
// Load data alignment: word loads rotate right by the byte offset, byte loads
// extract the addressed lane and zero-extend it.
module mem_bus_controller_read_data_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        byte_i,
    output logic [31:0] rdata_o
);
    logic [31:0] rot;
    logic [4:0]  lane_shift;

    assign lane_shift = {addr_lo_i, 3'b000};

    always_comb begin
        rot = rdata_i;
        case (addr_lo_i)
            2'd0: rot = rdata_i;
            2'd1: rot = {rdata_i[7:0],  rdata_i[31:8]};
            2'd2: rot = {rdata_i[15:0], rdata_i[31:16]};
            2'd3: rot = {rdata_i[23:0], rdata_i[31:24]};
            default: rot = rdata_i;
        endcase
    end

    assign rdata_o = byte_i ? {24'd0, rdata_i[lane_shift +: 8]} : rot;
endmodule

// File: rtl/mem_bus_controller.sv
// Sequences one CPU load/store onto the memory bus with a wait-state timeout.
// IDLE: wait for request | ADDR: address phase | ACCESS: bus cycle, wait for ready | DONE: response, turnaround
module mem_bus_controller
    import mem_bus_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_controller_if.master bus_io
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_req_q, mem_req_d;
    logic [1:0]  wdr_sel_q, wdr_sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rdata_aligned;
    logic        bus_phase_d;

    mem_bus_controller_read_data_align u_align (
        .rdata_i   (bus_io.mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .byte_i    (byte_q),
        .rdata_o   (rdata_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            wdr_sel_q   <= WDR_SEL_HIZ;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            mem_req_q   <= mem_req_d;
            wdr_sel_q   <= wdr_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        byte_d  = byte_q;
        // counts completed ACCESS cycles; zero on every entry to ACCESS
        cnt_d   = (state_q == ST_ACCESS) ? cnt_q + 8'd1 : 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.req_valid) begin
                    addr_d  = bus_io.req_addr;
                    write_d = bus_io.req_write;
                    byte_d  = bus_io.req_byte;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR:   state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus_io.mem_ready || (cnt_q == TO_LIMIT)) state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every bus/response pin is a flop.
    always_comb begin
        bus_phase_d = (state_d == ST_ADDR) || (state_d == ST_ACCESS);
        mem_addr_d  = bus_phase_d ? {addr_d[31:2], 2'b00} : 32'd0;
        mem_be_d    = bus_phase_d ? byte_enables(byte_d, addr_d[1:0]) : 4'd0;
        mem_we_d    = bus_phase_d && write_d;
        mem_req_d   = (state_d == ST_ACCESS);
        wdr_sel_d   = (bus_phase_d && write_d) ? WDR_SEL_LATCH : WDR_SEL_HIZ;
        rsp_valid_d = (state_d == ST_DONE);
        rsp_rdata_d = 32'd0;
        rsp_error_d = 1'b0;
        if (state_q == ST_ACCESS) begin
            if (bus_io.mem_ready) begin
                if (!write_q) rsp_rdata_d = rdata_aligned;
            end else if (cnt_q == TO_LIMIT) begin
                rsp_error_d = 1'b1;
            end
        end
    end

    assign bus_io.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_be    = mem_be_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_req   = mem_req_q;
    assign bus_io.wdr_sel   = wdr_sel_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_error = rsp_error_q;
endmodule
